sgdmac_rr_arbiter: RTL and testbench
====================================

SGDMAC_RR_ARBITER -- requirements
Module: sgdmac_rr_arbiter

Interface
REQ-001 SHALL provide parameter DATA_SIZE, default 32, payload width in bits.
REQ-002 SHALL provide parameter N_CH, default 2, number of source channels (legal range 2..8).
REQ-003 SHALL provide parameter PRIO_MODE, default 0: 0 = round-robin, 1 = fixed priority with channel 0 highest.
REQ-004 SHALL define ID_W = max(1, clog2(N_CH)).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 src_valid_i  input  N_CH  per-channel beat valid.
REQ-008 src_ready_o  output  N_CH  per-channel beat ready (combinational).
REQ-009 src_data_i  input  N_CH*DATA_SIZE  packed payloads; channel k occupies bits [k*DATA_SIZE +: DATA_SIZE].
REQ-010 src_last_i  input  N_CH  per-channel end-of-packet flag.
REQ-011 dst_valid_o  output  1  registered output beat valid.
REQ-012 dst_ready_i  input  1  downstream ready.
REQ-013 dst_data_o  output  DATA_SIZE  registered payload.
REQ-014 dst_last_o  output  1  registered end-of-packet flag.
REQ-015 dst_id_o  output  ID_W  registered index of the source channel of the current beat.

Function
REQ-016 A beat SHALL transfer on any port only when valid and ready are both high in the same cycle.
REQ-017 The output stage SHALL be one register slice; slot_free = !dst_valid_o || dst_ready_i.
REQ-018 The FSM SHALL have two states, IDLE and LOCK, plus registers lock_ch (ID_W bits) and rr_ptr (ID_W bits).
REQ-019 In IDLE the winner SHALL be the first channel with src_valid_i high: in PRIO_MODE=0 searching rr_ptr+1, rr_ptr+2, ... modulo N_CH; in PRIO_MODE=1 searching 0, 1, ....
REQ-020 In IDLE, src_ready_o SHALL be one-hot at the winner when a winner exists and slot_free=1, else all zero.
REQ-021 In LOCK, src_ready_o[lock_ch] SHALL equal slot_free and all other bits SHALL be 0; other channels' valids are ignored.
REQ-022 Each accepted source beat SHALL load dst_data_o, dst_last_o and dst_id_o and set dst_valid_o on the next edge (latency 1 cycle).
REQ-023 When dst_ready_i=1 and no source beat is accepted, dst_valid_o SHALL clear on the next edge; simultaneous drain and accept keeps dst_valid_o=1 (full throughput, 1 beat/cycle).
REQ-024 A beat accepted in IDLE with src_last_i=0 SHALL move the FSM to LOCK with lock_ch = winner.
REQ-025 A beat accepted with src_last_i=1 (in either state) SHALL leave the FSM in, or return it to, IDLE.
REQ-026 In PRIO_MODE=0, rr_ptr SHALL update to the channel index when that channel's beat with src_last_i=1 is accepted; it SHALL be unchanged otherwise.
REQ-027 A single-beat packet (last=1 on the first beat) SHALL be granted and released in one cycle with no LOCK visit.
REQ-028 While dst_valid_o=1 and dst_ready_i=0, dst_data_o/dst_last_o/dst_id_o SHALL hold stable.
REQ-029 src_valid_i deasserting mid-packet in LOCK SHALL NOT release the lock; the arbiter waits for the locked channel.
REQ-030 Index arithmetic SHALL wrap modulo N_CH, correct for non-power-of-two N_CH (e.g. 3: 2 -> 0).

Reset
REQ-031 On rst_n low, asynchronously: FSM=IDLE, lock_ch=0, rr_ptr=N_CH-1, dst_valid_o=0, dst_data_o=0, dst_last_o=0, dst_id_o=0.
REQ-032 While rst_n is low, src_ready_o SHALL be all zero.
REQ-033 Reset asserted mid-packet SHALL abandon the lock and discard any held output beat; after release, arbitration restarts from channel 0.

Verification
REQ-034 Reset then N_CH=3, RR, all valid, every beat last=1, dst_ready_i=1 -> dst_id_o sequence 0,1,2,0,1,2 on consecutive cycles, first dst_valid_o one cycle after first accept.
REQ-035 Ch1 sends 4-beat packet (data 0x10..0x13) while ch0, ch2 valid -> dst_data_o 0x10,0x11,0x12,0x13 contiguous, all dst_id_o=1, then ch2 granted.
REQ-036 dst_ready_i low for 3 cycles with beat 0xAA held -> dst_data_o=0xAA stable, src_ready_o all zero during stall, no beat lost or duplicated.
REQ-037 PRIO_MODE=1, ch0 and ch1 continuously valid single-beat packets -> ch1 never granted; ch0 deasserted -> ch1 granted next cycle.
REQ-038 Locked ch0 drops src_valid_i for 2 cycles mid-packet while ch1 valid -> ch1 not granted until ch0 last beat accepted.
REQ-039 rst_n pulsed low during LOCK with dst_valid_o=1 -> dst_valid_o=0 immediately, FSM IDLE, first grant after release to ch0.

Source files
------------

// File: rtl/sgdmac_rr_arbiter.sv
// rtl/sgdmac_rr_arbiter.sv - packet-locking N-channel stream arbiter with registered output slice
//
// Purpose:
//   Merges N_CH source beat streams into one destination stream. The first beat
//   of a packet is arbitrated (round-robin or fixed priority). Multi-beat packets
//   then hold the grant until their last beat has been accepted. The output is a
//   single register slice that sustains one beat per cycle.
//
// Ports:
//   clk          - sole clock, rising edge
//   rst_n        - asynchronous active-low reset
//   src_valid_i  - per-channel beat valid
//   src_ready_o  - per-channel beat ready (combinational)
//   src_data_i   - packed payloads, channel k at [k*DATA_SIZE +: DATA_SIZE]
//   src_last_i   - per-channel end-of-packet flag
//   dst_valid_o  - registered output beat valid
//   dst_ready_i  - downstream ready
//   dst_data_o   - registered payload
//   dst_last_o   - registered end-of-packet flag
//   dst_id_o     - registered source channel index of the current beat

module sgdmac_rr_arbiter #(
    parameter int DATA_SIZE = 32,
    parameter int N_CH      = 2,
    parameter int PRIO_MODE = 0,
    localparam int ID_W     = (N_CH > 2) ? $clog2(N_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_CH-1:0]           src_valid_i,
    output logic [N_CH-1:0]           src_ready_o,
    input  logic [N_CH*DATA_SIZE-1:0] src_data_i,
    input  logic [N_CH-1:0]           src_last_i,
    output logic                      dst_valid_o,
    input  logic                      dst_ready_i,
    output logic [DATA_SIZE-1:0]      dst_data_o,
    output logic                      dst_last_o,
    output logic [ID_W-1:0]           dst_id_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // rr_ptr starts at the last channel so the first search begins at channel 0.
    localparam logic [ID_W-1:0] RR_PTR_RST = ID_W'(N_CH - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ID_W-1:0]       r_lock_ch;
    logic [ID_W-1:0]       w_lock_ch_nxt;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [ID_W-1:0]       w_rr_ptr_nxt;

    logic                  r_dst_valid;
    logic [DATA_SIZE-1:0]  r_dst_data;
    logic                  r_dst_last;
    logic [ID_W-1:0]       r_dst_id;

    logic                  w_slot_free;
    logic                  w_found;
    logic [ID_W-1:0]       w_cand;
    logic [ID_W-1:0]       w_winner;
    logic [ID_W-1:0]       w_sel;
    logic [N_CH-1:0]       w_ready;
    logic                  w_accept;
    logic                  w_sel_last;
    logic [DATA_SIZE-1:0]  w_src_data [N_CH];

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_unpack
            assign w_src_data[g] = src_data_i[g*DATA_SIZE +: DATA_SIZE];
        end
    endgenerate

    // The output slice can take a new beat when empty or draining this cycle.
    assign w_slot_free = !r_dst_valid || dst_ready_i;

    // First valid channel in search order. Round-robin starts one past the
    // channel that last completed a packet; the modulo keeps non-power-of-two
    // channel counts wrapping correctly.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (PRIO_MODE == 1) begin
                w_cand = ID_W'(i);
            end else begin
                w_cand = ID_W'((int'(r_rr_ptr) + 1 + i) % N_CH);
            end
            if (!w_found && src_valid_i[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    assign w_sel = (r_state == ST_LOCK) ? r_lock_ch : w_winner;

    // While locked, the locked channel sees ready whenever the slot is free,
    // regardless of its valid; all other channels are ignored. The rst_n term
    // keeps ready low during reset even though the search logic is live.
    always_comb begin
        w_ready = '0;
        if (rst_n && w_slot_free && ((r_state == ST_LOCK) || w_found)) begin
            w_ready[w_sel] = 1'b1;
        end
    end

    assign src_ready_o = w_ready;
    assign w_accept    = |(w_ready & src_valid_i);
    assign w_sel_last  = src_last_i[w_sel];

    always_comb begin
        w_state_nxt   = r_state;
        w_lock_ch_nxt = r_lock_ch;
        w_rr_ptr_nxt  = r_rr_ptr;
        if (w_accept) begin
            if (w_sel_last) begin
                // Covers both the end of a locked packet and a single-beat
                // packet granted straight from IDLE.
                w_state_nxt = ST_IDLE;
                if (PRIO_MODE == 0) begin
                    w_rr_ptr_nxt = w_sel;
                end
            end else if (r_state == ST_IDLE) begin
                w_state_nxt   = ST_LOCK;
                w_lock_ch_nxt = w_winner;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_lock_ch <= '0;
            r_rr_ptr  <= RR_PTR_RST;
        end else begin
            r_state   <= w_state_nxt;
            r_lock_ch <= w_lock_ch_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
        end
    end

    // Output register slice: load on accept, otherwise drop valid once drained.
    // Payload fields only change on accept, so they hold during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dst_valid <= 1'b0;
            r_dst_data  <= '0;
            r_dst_last  <= 1'b0;
            r_dst_id    <= '0;
        end else if (w_accept) begin
            r_dst_valid <= 1'b1;
            r_dst_data  <= w_src_data[w_sel];
            r_dst_last  <= w_sel_last;
            r_dst_id    <= w_sel;
        end else if (dst_ready_i) begin
            r_dst_valid <= 1'b0;
        end
    end

    assign dst_valid_o = r_dst_valid;
    assign dst_data_o  = r_dst_data;
    assign dst_last_o  = r_dst_last;
    assign dst_id_o    = r_dst_id;

endmodule

// File: tb/tb_sgdmac_rr_arbiter.sv
// tb/tb_sgdmac_rr_arbiter.sv - directed self-checking bench for sgdmac_rr_arbiter

module tb_sgdmac_rr_arbiter;

    logic        clk;
    logic        rst_n;

    // Round-robin instance, 3 channels.
    logic [2:0]  src_valid;
    logic [2:0]  src_ready;
    logic [95:0] src_data;
    logic [2:0]  src_last;
    logic        dst_valid;
    logic        dst_ready;
    logic [31:0] dst_data;
    logic        dst_last;
    logic [1:0]  dst_id;

    // Fixed-priority instance, 2 channels.
    logic [1:0]  p_valid;
    logic [1:0]  p_ready;
    logic [63:0] p_data;
    logic [1:0]  p_last;
    logic        p_dst_valid;
    logic        p_dst_ready;
    logic [31:0] p_dst_data;
    logic        p_dst_last;
    logic [0:0]  p_dst_id;

    int n_cmp = 0;
    int n_bad = 0;

    sgdmac_rr_arbiter #(.DATA_SIZE(32), .N_CH(3), .PRIO_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_valid_i(src_valid), .src_ready_o(src_ready),
        .src_data_i(src_data), .src_last_i(src_last),
        .dst_valid_o(dst_valid), .dst_ready_i(dst_ready),
        .dst_data_o(dst_data), .dst_last_o(dst_last), .dst_id_o(dst_id)
    );

    sgdmac_rr_arbiter #(.DATA_SIZE(32), .N_CH(2), .PRIO_MODE(1)) dutp (
        .clk(clk), .rst_n(rst_n),
        .src_valid_i(p_valid), .src_ready_o(p_ready),
        .src_data_i(p_data), .src_last_i(p_last),
        .dst_valid_o(p_dst_valid), .dst_ready_i(p_dst_ready),
        .dst_data_o(p_dst_data), .dst_last_o(p_dst_last), .dst_id_o(p_dst_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic v, input logic [31:0] d, input logic l);
        src_valid[k]         = v;
        src_data[k*32 +: 32] = d;
        src_last[k]          = l;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        src_valid = '0; src_data = '0; src_last = '0; dst_ready = 1'b0;
        p_valid = '0; p_data = '0; p_last = '0; p_dst_ready = 1'b0;

        // Reset state, with all sources valid: ready must stay low.
        edge1();
        for (int k = 0; k < 3; k++) set_ch(k, 1'b1, 32'hC0 + 32'(k), 1'b1);
        dst_ready = 1'b1;
        #1;
        chk("rst_ready",   32'(src_ready), 32'h0);
        chk("rst_valid",   32'(dst_valid), 32'h0);
        chk("rst_id",      32'(dst_id), 32'h0);
        chk("rst_data",    dst_data, 32'h0);
        chk("rst_last",    32'(dst_last), 32'h0);
        chk("rst_p_valid", 32'(p_dst_valid), 32'h0);

        // Round-robin over 3 single-beat channels: ids 0,1,2,0,1,2.
        rst_n = 1'b1;
        #1;
        chk("rr_first_ready", 32'(src_ready), 32'h1);
        chk("rr_pre_valid",   32'(dst_valid), 32'h0);
        for (int i = 0; i < 6; i++) begin
            edge1();
            chk("rr_valid", 32'(dst_valid), 32'h1);
            chk("rr_id",    32'(dst_id), 32'(i % 3));
            chk("rr_data",  dst_data, 32'hC0 + 32'(i % 3));
            chk("rr_last",  32'(dst_last), 32'h1);
            chk("rr_next_ready", 32'(src_ready), 32'h1 << ((i + 1) % 3));
        end

        // Move rr_ptr to 0 with one ch0 beat.
        src_valid = '0;
        set_ch(0, 1'b1, 32'h01, 1'b1);
        #1;
        chk("pre_ready", 32'(src_ready), 32'h1);
        edge1();
        chk("pre_id", 32'(dst_id), 32'h0);

        // 4-beat ch1 packet while ch0 and ch2 are valid.
        set_ch(0, 1'b1, 32'h02, 1'b1);
        set_ch(2, 1'b1, 32'h22, 1'b1);
        for (int b = 0; b < 4; b++) begin
            set_ch(1, 1'b1, 32'h10 + 32'(b), (b == 3));
            #1;
            chk("pkt_ready", 32'(src_ready), 32'h2);
            edge1();
            chk("pkt_data",  dst_data, 32'h10 + 32'(b));
            chk("pkt_id",    32'(dst_id), 32'h1);
            chk("pkt_valid", 32'(dst_valid), 32'h1);
        end
        set_ch(1, 1'b0, 32'h0, 1'b0);
        #1;
        chk("pkt_after_ready", 32'(src_ready), 32'h4);
        edge1();
        chk("pkt_after_id",   32'(dst_id), 32'h2);
        chk("pkt_after_data", dst_data, 32'h22);

        // Stall: 0xAA held for 3 cycles, 0xBB must follow exactly once.
        src_valid = '0;
        set_ch(0, 1'b1, 32'hAA, 1'b1);
        #1;
        chk("stall_pre_ready", 32'(src_ready), 32'h1);
        edge1();
        chk("stall_load", dst_data, 32'hAA);
        dst_ready = 1'b0;
        set_ch(0, 1'b1, 32'hBB, 1'b1);
        #1;
        chk("stall_ready0", 32'(src_ready), 32'h0);
        for (int s = 0; s < 3; s++) begin
            edge1();
            chk("stall_data",  dst_data, 32'hAA);
            chk("stall_valid", 32'(dst_valid), 32'h1);
            chk("stall_ready", 32'(src_ready), 32'h0);
        end
        dst_ready = 1'b1;
        #1;
        chk("unstall_ready", 32'(src_ready), 32'h1);
        edge1();
        chk("unstall_data",  dst_data, 32'hBB);
        chk("unstall_valid", 32'(dst_valid), 32'h1);
        set_ch(0, 1'b0, 32'h0, 1'b0);
        edge1();
        chk("drain_valid", 32'(dst_valid), 32'h0);

        // Locked ch0 drops valid for 2 cycles; ch1 must wait.
        set_ch(0, 1'b1, 32'h20, 1'b0);
        #1;
        chk("lk_ready0", 32'(src_ready), 32'h1);
        edge1();
        chk("lk_data0", dst_data, 32'h20);
        chk("lk_id0",   32'(dst_id), 32'h0);
        set_ch(0, 1'b0, 32'h0, 1'b0);
        set_ch(1, 1'b1, 32'h77, 1'b1);
        #1;
        chk("lk_gap_ready_a", 32'(src_ready), 32'h1);
        edge1();
        chk("lk_gap_valid",   32'(dst_valid), 32'h0);
        chk("lk_gap_ready_b", 32'(src_ready), 32'h1);
        edge1();
        chk("lk_gap_ready_c", 32'(src_ready), 32'h1);
        set_ch(0, 1'b1, 32'h21, 1'b1);
        #1;
        chk("lk_last_ready", 32'(src_ready), 32'h1);
        edge1();
        chk("lk_last_data", dst_data, 32'h21);
        chk("lk_last_id",   32'(dst_id), 32'h0);
        chk("lk_last_last", 32'(dst_last), 32'h1);
        set_ch(0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("lk_ch1_ready", 32'(src_ready), 32'h2);
        edge1();
        chk("lk_ch1_id",   32'(dst_id), 32'h1);
        chk("lk_ch1_data", dst_data, 32'h77);
        set_ch(1, 1'b0, 32'h0, 1'b0);

        // Reset pulse during LOCK with a held output beat.
        set_ch(2, 1'b1, 32'h30, 1'b0);
        #1;
        chk("mr_ready", 32'(src_ready), 32'h4);
        edge1();
        chk("mr_id",    32'(dst_id), 32'h2);
        chk("mr_valid", 32'(dst_valid), 32'h1);
        dst_ready = 1'b0;
        set_ch(0, 1'b1, 32'h40, 1'b1);
        set_ch(2, 1'b1, 32'h31, 1'b0);
        #1;
        chk("mr_stall_ready", 32'(src_ready), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_rst_valid", 32'(dst_valid), 32'h0);
        chk("mr_rst_id",    32'(dst_id), 32'h0);
        chk("mr_rst_ready", 32'(src_ready), 32'h0);
        #2;
        rst_n = 1'b1;
        dst_ready = 1'b1;
        #1;
        chk("mr_rel_ready", 32'(src_ready), 32'h1);
        edge1();
        chk("mr_rel_id",   32'(dst_id), 32'h0);
        chk("mr_rel_data", dst_data, 32'h40);
        src_valid = '0;

        // Fixed priority: ch1 starved while ch0 is valid.
        p_valid = 2'b11;
        p_last  = 2'b11;
        p_data  = {32'h51, 32'h50};
        p_dst_ready = 1'b1;
        #1;
        chk("pr_ready0", 32'(p_ready), 32'h1);
        for (int i = 0; i < 4; i++) begin
            edge1();
            chk("pr_id",    32'(p_dst_id), 32'h0);
            chk("pr_data",  p_dst_data, 32'h50);
            chk("pr_ready", 32'(p_ready), 32'h1);
        end
        p_valid = 2'b10;
        #1;
        chk("pr_ch1_ready", 32'(p_ready), 32'h2);
        edge1();
        chk("pr_ch1_id",   32'(p_dst_id), 32'h1);
        chk("pr_ch1_data", p_dst_data, 32'h51);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
